net_port_supervisor: RTL and testbench

Per-port supervisor for a parametrised set of Ethernet ports, generalising the fixed single-PHY power-on reset counter and hard-wired link/fault LEDs of the current network interface block. It runs a PHY reset sequencer per port with soft-reset requests, tracks link state, drives link/fault and stretched activity LEDs, and keeps saturating link-flap counters. It sits beside the MAC wrappers in the network interface block. All status inputs are already synchronised to `clk_125mhz`.

---
 rtl/net_port_supervisor.sv | 159 +++++++++++++++
 tb/tb_net_port_supervisor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_port_supervisor.sv
// net_port_supervisor
//   Per-port supervisor for a set of Ethernet ports. Each port runs a PHY reset
//   sequencer (restartable by a soft request), tracks link state, drives link
//   and activity LEDs, and keeps a saturating link-flap counter. A single blink
//   phase generator is shared by all ports for the remote-fault indication.
//
// Ports
//   clk_125mhz    in  1            only clock
//   rst           in  1            synchronous active-high reset
//   phy_rst_req   in  NUM_PORTS    pulse: restart that port's PHY reset sequence
//   link_up       in  NUM_PORTS    link level from the MAC wrapper
//   remote_fault  in  NUM_PORTS    remote fault level from the MAC wrapper
//   rx_activity   in  NUM_PORTS    pulse per received frame
//   tx_activity   in  NUM_PORTS    pulse per transmitted frame
//   flap_clr      in  NUM_PORTS    pulse: clear that port's flap counter
//   phy_rst_n     out NUM_PORTS    active-low PHY reset (registered)
//   port_up       out NUM_PORTS    port is in the UP state
//   link_change   out NUM_PORTS    pulse on entry to or exit from UP
//   led_link      out NUM_PORTS    link LED, blinks on remote fault
//   led_act       out NUM_PORTS    stretched activity LED
//   flap_count    out NUM_PORTS*16 saturating link-loss counters
module net_port_supervisor #(
   parameter int unsigned NUM_PORTS          = 4,
   parameter int unsigned RST_CYCLES         = 262144,
   parameter int unsigned ACT_STRETCH_CYCLES = 6250000,
   parameter int unsigned BLINK_HALF_CYCLES  = 15625000
) (
   input  logic                        clk_125mhz,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        phy_rst_req,
   input  logic [NUM_PORTS-1:0]        link_up,
   input  logic [NUM_PORTS-1:0]        remote_fault,
   input  logic [NUM_PORTS-1:0]        rx_activity,
   input  logic [NUM_PORTS-1:0]        tx_activity,
   input  logic [NUM_PORTS-1:0]        flap_clr,
   output logic [NUM_PORTS-1:0]        phy_rst_n,
   output logic [NUM_PORTS-1:0]        port_up,
   output logic [NUM_PORTS-1:0]        link_change,
   output logic [NUM_PORTS-1:0]        led_link,
   output logic [NUM_PORTS-1:0]        led_act,
   output logic [NUM_PORTS-1:0][15:0]  flap_count
);

   localparam int unsigned RstW   = $clog2(RST_CYCLES + 1);
   localparam int unsigned ActW   = $clog2(ACT_STRETCH_CYCLES + 1);
   localparam int unsigned BlinkW = $clog2(BLINK_HALF_CYCLES + 1);

   localparam logic [RstW-1:0]   RstLast   = RstW'(RST_CYCLES - 1);
   localparam logic [ActW-1:0]   ActLoad   = ActW'(ACT_STRETCH_CYCLES);
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF_CYCLES - 1);

   typedef enum logic [1:0] {StReset, StWaitLink, StUp} state_e;

   state_e                      state_q     [NUM_PORTS];
   state_e                      state_d     [NUM_PORTS];
   logic [RstW-1:0]             rst_cnt_q   [NUM_PORTS];
   logic [RstW-1:0]             rst_cnt_d   [NUM_PORTS];
   logic [ActW-1:0]             act_cnt_q   [NUM_PORTS];
   logic [ActW-1:0]             act_cnt_d   [NUM_PORTS];
   logic [NUM_PORTS-1:0][15:0]  flap_q, flap_d;
   logic [NUM_PORTS-1:0]        phy_rst_n_q, phy_rst_n_d;
   logic [NUM_PORTS-1:0]        link_change_q, link_change_d;
   logic [BlinkW-1:0]           blink_cnt_q, blink_cnt_d;
   logic                        blink_phase_q, blink_phase_d;

   always_comb begin
      blink_cnt_d   = blink_cnt_q + BlinkW'(1);
      blink_phase_d = blink_phase_q;
      if (blink_cnt_q == BlinkLast) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end

      for (int p = 0; p < NUM_PORTS; p++) begin
         state_d[p]   = state_q[p];
         rst_cnt_d[p] = rst_cnt_q[p];
         act_cnt_d[p] = act_cnt_q[p];
         flap_d[p]    = flap_q[p];

         case (state_q[p])
            StReset: begin
               if (rst_cnt_q[p] == RstLast) state_d[p] = StWaitLink;
               else                         rst_cnt_d[p] = rst_cnt_q[p] + RstW'(1);
            end
            StWaitLink: begin
               if (link_up[p]) state_d[p] = StUp;
            end
            StUp: begin
               if (!link_up[p]) begin
                  state_d[p] = StWaitLink;
                  if (flap_q[p] != 16'hFFFF) flap_d[p] = flap_q[p] + 16'd1;
               end
            end
            default: state_d[p] = StReset;
         endcase

         // A soft reset is not a link flap: undo any increment from a coincident loss.
         if (phy_rst_req[p]) begin
            state_d[p]   = StReset;
            rst_cnt_d[p] = '0;
            flap_d[p]    = flap_q[p];
         end

         if (flap_clr[p]) flap_d[p] = '0;

         // Activity only counts when the port was already UP and stays UP.
         if (state_d[p] != StUp) begin
            act_cnt_d[p] = '0;
         end else if (state_q[p] == StUp && (rx_activity[p] || tx_activity[p])) begin
            act_cnt_d[p] = ActLoad;
         end else if (act_cnt_q[p] != '0) begin
            act_cnt_d[p] = act_cnt_q[p] - ActW'(1);
         end

         link_change_d[p] = (state_q[p] == StUp) != (state_d[p] == StUp);
         // Lags the state by one edge so the pin stays low RST_CYCLES full cycles.
         phy_rst_n_d[p]   = !phy_rst_req[p] && (state_q[p] != StReset);
      end
   end

   always_ff @(posedge clk_125mhz) begin
      if (rst) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            state_q[p]   <= StReset;
            rst_cnt_q[p] <= '0;
            act_cnt_q[p] <= '0;
         end
         flap_q        <= '0;
         phy_rst_n_q   <= '0;
         link_change_q <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            state_q[p]   <= state_d[p];
            rst_cnt_q[p] <= rst_cnt_d[p];
            act_cnt_q[p] <= act_cnt_d[p];
         end
         flap_q        <= flap_d;
         phy_rst_n_q   <= phy_rst_n_d;
         link_change_q <= link_change_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         port_up[p]  = (state_q[p] == StUp);
         led_link[p] = port_up[p] && (!remote_fault[p] || blink_phase_q);
         led_act[p]  = (act_cnt_q[p] != '0);
      end
   end

   assign phy_rst_n   = phy_rst_n_q;
   assign link_change = link_change_q;
   assign flap_count  = flap_q;

endmodule

// File: tb/tb_net_port_supervisor.sv
module tb_net_port_supervisor;

   localparam int NP = 2;
   localparam int RC = 16;
   localparam int AC = 8;
   localparam int BH = 4;

   logic clk = 1'b0;
   always #4 clk = ~clk;

   logic                 rst;
   logic [NP-1:0]        phy_rst_req, link_up, remote_fault, rx_activity, tx_activity, flap_clr;
   logic [NP-1:0]        phy_rst_n, port_up, link_change, led_link, led_act;
   logic [NP-1:0][15:0]  flap_count;

   net_port_supervisor #(
      .NUM_PORTS          (NP),
      .RST_CYCLES         (RC),
      .ACT_STRETCH_CYCLES (AC),
      .BLINK_HALF_CYCLES  (BH)
   ) dut (
      .clk_125mhz   (clk),
      .rst          (rst),
      .phy_rst_req  (phy_rst_req),
      .link_up      (link_up),
      .remote_fault (remote_fault),
      .rx_activity  (rx_activity),
      .tx_activity  (tx_activity),
      .flap_clr     (flap_clr),
      .phy_rst_n    (phy_rst_n),
      .port_up      (port_up),
      .link_change  (link_change),
      .led_link     (led_link),
      .led_act      (led_act),
      .flap_count   (flap_count)
   );

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: event times since the last reset, not a state machine.
   int n;                 // edges since the last rst edge
   int rst_start [NP];    // edge at which the current PHY reset began
   bit m_up      [NP];
   bit m_chg     [NP];
   int m_flap    [NP];
   bit act_valid [NP];
   int last_act  [NP];

   task automatic model_edge();
      bit was_up, in_wait;
      if (rst) begin
         n = 0;
         for (int p = 0; p < NP; p++) begin
            rst_start[p] = 0; m_up[p] = 0; m_chg[p] = 0; m_flap[p] = 0; act_valid[p] = 0;
            last_act[p] = 0;
         end
      end else begin
         n++;
         for (int p = 0; p < NP; p++) begin
            was_up  = m_up[p];
            in_wait = !was_up && ((n - 1) >= rst_start[p] + RC);
            m_chg[p] = 0;
            if (phy_rst_req[p]) begin
               rst_start[p] = n;
               m_up[p]      = 0;
               m_chg[p]     = was_up;
            end else if (was_up && !link_up[p]) begin
               m_up[p]  = 0;
               m_chg[p] = 1;
               if (m_flap[p] < 65535) m_flap[p]++;
            end else if (in_wait && link_up[p]) begin
               m_up[p]  = 1;
               m_chg[p] = 1;
            end
            if (flap_clr[p]) m_flap[p] = 0;
            if (!m_up[p]) act_valid[p] = 0;
            else if (was_up && (rx_activity[p] || tx_activity[p])) begin
               act_valid[p] = 1;
               last_act[p]  = n;
            end
         end
      end
   endtask

   task automatic expect_bits(input string tag, input logic [NP-1:0] got, input logic [NP-1:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fails++;
         $error("FAIL %s cycle %0d: observed %b expected %b", tag, n, got, exp);
      end
   endtask

   task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fails++;
         $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, n, got, exp);
      end
   endtask

   task automatic check_model();
      logic [NP-1:0] e_phy, e_up, e_chg, e_link, e_act;
      for (int p = 0; p < NP; p++) begin
         e_phy[p]  = (n >= rst_start[p] + RC + 1);
         e_up[p]   = m_up[p];
         e_chg[p]  = m_chg[p];
         e_link[p] = m_up[p] && (!remote_fault[p] || ((n / BH) % 2 == 1));
         e_act[p]  = act_valid[p] && ((n - last_act[p]) < AC);
      end
      expect_bits("phy_rst_n", phy_rst_n, e_phy);
      expect_bits("port_up", port_up, e_up);
      expect_bits("link_change", link_change, e_chg);
      expect_bits("led_link", led_link, e_link);
      expect_bits("led_act", led_act, e_act);
      for (int p = 0; p < NP; p++) expect_val("flap_count", 32'(flap_count[p]), 32'(m_flap[p]));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
      phy_rst_req = '0;
      flap_clr    = '0;
      rx_activity = '0;
      tx_activity = '0;
   endtask

   int pulses, lows, highs;

   initial begin
      rst = 1'b1;
      phy_rst_req = '0; link_up = '0; remote_fault = '0;
      rx_activity = '0; tx_activity = '0; flap_clr = '0;
      n = 0;
      for (int p = 0; p < NP; p++) begin
         rst_start[p] = 0; m_up[p] = 0; m_chg[p] = 0; m_flap[p] = 0; act_valid[p] = 0;
         last_act[p] = 0;
      end

      // Power-up
      repeat (3) step();
      expect_bits("reset_phy", phy_rst_n, 2'b00);
      expect_bits("reset_led_link", led_link, 2'b00);
      rst = 1'b0;
      lows = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (phy_rst_n == 2'b00) lows++;
      end
      expect_val("powerup_low_cycles", 32'(lows), 32'd16);
      step();
      expect_bits("powerup_phy_high", phy_rst_n, 2'b11);

      // Link cycling on port 0
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         link_up[0] = 1'b1;
         for (int i = 0; i < 10; i++) begin step(); if (link_change[0]) pulses++; end
         link_up[0] = 1'b0;
         for (int i = 0; i < 10; i++) begin step(); if (link_change[0]) pulses++; end
      end
      expect_val("flap_pulses", 32'(pulses), 32'd6);
      expect_val("flap0_after3", 32'(flap_count[0]), 32'd3);
      expect_val("flap1_after3", 32'(flap_count[1]), 32'd0);

      // Saturation
      link_up[0] = 1'b1;
      repeat (3) step();
      force dut.flap_q = {16'h0000, 16'hFFFF};
      m_flap[0] = 65535;
      step();
      release dut.flap_q;
      link_up[0] = 1'b0;
      step();
      expect_val("flap_saturate", 32'(flap_count[0]), 32'hFFFF);
      flap_clr[0] = 1'b1;
      step();

      // Soft reset of port 1 while UP
      link_up = 2'b11;
      repeat (3) step();
      expect_bits("both_up", port_up, 2'b11);
      phy_rst_req[1] = 1'b1;
      pulses = 0;
      step();
      if (link_change[1]) pulses++;
      expect_bits("req_port1_down", port_up, 2'b01);
      for (int i = 0; i < 9; i++) begin step(); if (link_change[1]) pulses++; end
      expect_val("req_pulses", 32'(pulses), 32'd1);
      expect_val("req_flap1", 32'(flap_count[1]), 32'd0);
      phy_rst_req[1] = 1'b1;
      step();
      lows = 0;
      for (int i = 0; i < 40 && !phy_rst_n[1]; i++) begin
         step();
         if (!phy_rst_n[1]) lows++;
      end
      expect_val("req_restart_low", 32'(lows), 32'd16);
      repeat (3) step();

      // Activity stretch with retrigger
      rx_activity[0] = 1'b1;
      step();
      highs = led_act[0] ? 1 : 0;
      for (int i = 1; i < 20; i++) begin
         if (i == 5) tx_activity[0] = 1'b1;
         step();
         if (led_act[0]) highs++;
      end
      expect_val("act_stretch_cycles", 32'(highs), 32'd13);
      link_up[0] = 1'b0;
      step();
      rx_activity[0] = 1'b1;
      step();
      expect_bits("act_in_wait", led_act, 2'b00);

      // Remote fault blink
      link_up[0] = 1'b1;
      step();
      remote_fault[0] = 1'b1;
      repeat (16) step();
      remote_fault[0] = 1'b0;
      repeat (4) step();

      // Clear coincident with link loss at count 5
      flap_clr[0] = 1'b1;
      step();
      for (int k = 0; k < 5; k++) begin
         link_up[0] = 1'b0; repeat (2) step();
         link_up[0] = 1'b1; repeat (2) step();
      end
      expect_val("flap_five", 32'(flap_count[0]), 32'd5);
      link_up[0] = 1'b0;
      flap_clr[0] = 1'b1;
      step();
      expect_val("clr_wins", 32'(flap_count[0]), 32'd0);

      // Reset pulse with both ports UP
      link_up = 2'b11;
      repeat (3) step();
      rst = 1'b1;
      step();
      expect_bits("rst_port_up", port_up, 2'b00);
      expect_bits("rst_phy", phy_rst_n, 2'b00);
      rst = 1'b0;
      repeat (20) step();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 499) == 0);
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 7) == 0)  link_up[p]      = ~link_up[p];
            if ($urandom_range(0, 15) == 0) remote_fault[p] = ~remote_fault[p];
            rx_activity[p] = ($urandom_range(0, 5) == 0);
            tx_activity[p] = ($urandom_range(0, 5) == 0);
            phy_rst_req[p] = ($urandom_range(0, 63) == 0);
            flap_clr[p]    = ($urandom_range(0, 63) == 0);
         end
         step();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
